// File: rtl/datapath_seq.sv
// Sequencer for a fixed register-transfer program: CLEAR, LOAD, OP1..OP4, FIN.
// Every output is a register loaded from the decode of the next state.
module datapath_seq #(
    parameter int HOLD = 2  // cycles per timed step, legal 1..15
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       cin_req_i,
    output logic       dp_clr_o,
    output logic       cin_o,
    output logic [2:0] w_o,
    output logic [3:0] ce_o,
    output logic [1:0] sel_o,
    output logic [2:0] s_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] step_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_OP1   = 3'd3,
        ST_OP2   = 3'd4,
        ST_OP3   = 3'd5,
        ST_OP4   = 3'd6,
        ST_FIN   = 3'd7
    } state_e;

    typedef struct packed {
        logic       dp_clr;
        logic [2:0] w;
        logic [3:0] ce;
        logic [1:0] sel;
        logic [2:0] s;
    } word_t;

    localparam logic [3:0] DWELL_LAST = 4'(HOLD - 1);
    localparam word_t      WORD_IDLE  = '{dp_clr: 1'b0, w: 3'b000, ce: 4'b0000, sel: 2'b11, s: 3'b000};

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cin_q, cin_d;
    word_t      word_q, word_d;
    logic       busy_q, done_q;

    function automatic word_t decode(input state_e st);
        word_t wd;
        wd = WORD_IDLE;
        case (st)
            ST_CLEAR: wd = '{dp_clr: 1'b1, w: 3'b000, ce: 4'b0000, sel: 2'b11, s: 3'b000};
            ST_LOAD:  wd = '{dp_clr: 1'b0, w: 3'b000, ce: 4'b0001, sel: 2'b00, s: 3'b010};
            ST_OP1:   wd = '{dp_clr: 1'b0, w: 3'b000, ce: 4'b1000, sel: 2'b00, s: 3'b010};
            ST_OP2:   wd = '{dp_clr: 1'b0, w: 3'b010, ce: 4'b0010, sel: 2'b10, s: 3'b001};
            ST_OP3:   wd = '{dp_clr: 1'b0, w: 3'b000, ce: 4'b1000, sel: 2'b10, s: 3'b001};
            ST_OP4:   wd = '{dp_clr: 1'b0, w: 3'b100, ce: 4'b0100, sel: 2'b10, s: 3'b001};
            default:  wd = WORD_IDLE;
        endcase
        return wd;
    endfunction

    function automatic state_e next_step(input state_e st);
        state_e nx;
        case (st)
            ST_CLEAR: nx = ST_LOAD;
            ST_LOAD:  nx = ST_OP1;
            ST_OP1:   nx = ST_OP2;
            ST_OP2:   nx = ST_OP3;
            ST_OP3:   nx = ST_OP4;
            ST_OP4:   nx = ST_FIN;
            default:  nx = ST_IDLE;
        endcase
        return nx;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = DWELL_LAST;
                    cin_d   = cin_req_i;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                // Timed steps: counter reloads on entry, advance when it reaches zero.
                if (cnt_q == 4'd0) begin
                    state_d = next_step(state_q);
                    cnt_d   = (state_q == ST_OP4) ? 4'd0 : DWELL_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        // Abort outranks both normal advance and the dwell expiry.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end
        word_d = decode(state_d);
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cin_q   <= 1'b0;
            word_q  <= WORD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
            word_q  <= word_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN);
        end
    end

    assign dp_clr_o = word_q.dp_clr;
    assign w_o      = word_q.w;
    assign ce_o     = word_q.ce;
    assign sel_o    = word_q.sel;
    assign s_o      = word_q.s;
    assign cin_o    = cin_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign step_o   = state_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: HOLD=2 instance for the main program,
// HOLD=1 instance for back-to-back programs under a held START.
module tb_datapath_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, start, abort, cin_req, start2;
    logic       dp_clr, cin, busy, done;
    logic [2:0] w, s, step;
    logic [3:0] ce;
    logic [1:0] sel;
    logic       dp_clr2, cin2, busy2, done2;
    logic [2:0] w2, s2, step2;
    logic [3:0] ce2;
    logic [1:0] sel2;

    int n_pass  = 0;
    int n_total = 0;
    logic [2:0] exp_q[$];

    datapath_seq #(.HOLD(2)) dut (
        .clk_i(clk), .clr_i(clr), .start_i(start), .abort_i(abort), .cin_req_i(cin_req),
        .dp_clr_o(dp_clr), .cin_o(cin), .w_o(w), .ce_o(ce), .sel_o(sel), .s_o(s),
        .busy_o(busy), .done_o(done), .step_o(step)
    );

    datapath_seq #(.HOLD(1)) dut2 (
        .clk_i(clk), .clr_i(clr), .start_i(start2), .abort_i(1'b0), .cin_req_i(1'b0),
        .dp_clr_o(dp_clr2), .cin_o(cin2), .w_o(w2), .ce_o(ce2), .sel_o(sel2), .s_o(s2),
        .busy_o(busy2), .done_o(done2), .step_o(step2)
    );

    // Expected {dp_clr, w, ce, sel, s} for each step, from the program table.
    function automatic logic [12:0] word_of(input logic [2:0] st);
        case (st)
            3'd1:    return 13'b1_000_0000_11_000;
            3'd2:    return 13'b0_000_0001_00_010;
            3'd3:    return 13'b0_000_1000_00_010;
            3'd4:    return 13'b0_010_0010_10_001;
            3'd5:    return 13'b0_000_1000_10_001;
            3'd6:    return 13'b0_100_0100_10_001;
            default: return 13'b0_000_0000_11_000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic exp_cin);
        chk({tag, ".step"}, 32'(step), 32'(st));
        chk({tag, ".word"}, 32'({dp_clr, w, ce, sel, s}), 32'(word_of(st)));
        chk({tag, ".busy"}, 32'(busy), 32'(st != 3'd0));
        chk({tag, ".done"}, 32'(done), 32'(st == 3'd7));
        chk({tag, ".cin"}, 32'(cin), 32'(exp_cin));
    endtask

    // Full HOLD=2 program; optional START pulses during LOAD (cycle 3) and FIN (cycle 13).
    task automatic run_prog(input string tag, input logic creq, input logic pulses);
        logic [2:0] st;
        exp_q = {3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0, 3'd0};
        cin_req = creq;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cin_req = ~creq;
        for (int c = 1; c <= 15; c++) begin
            st = exp_q.pop_front();
            chk_all($sformatf("%s.c%0d", tag, c), st, creq);
            start = pulses && (c == 3 || c == 13);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; abort = 1'b0; cin_req = 1'b0; start2 = 1'b0;
        #2;
        chk_all("reset", 3'd0, 1'b0);
        chk("reset.step2", 32'(step2), 32'd0);
        chk("reset.sel2", 32'(sel2), 32'd3);
        @(negedge clk);
        clr = 1'b0;
        tick();
        chk_all("idle", 3'd0, 1'b0);

        run_prog("prog0", 1'b0, 1'b0);
        run_prog("cin1", 1'b1, 1'b0);
        run_prog("cin0_pulses", 1'b0, 1'b1);

        // Abort in OP2 at its dwell-expiry cycle, CIN captured as 1 must survive.
        cin_req = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cin_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk("abort.done_low", 32'(done), 32'd0);
            tick();
        end
        chk("abort.in_op2", 32'(step), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort.c9", 3'd0, 1'b1);
        tick();
        chk_all("abort.c10", 3'd0, 1'b1);

        // START and ABORT together in IDLE: START wins.
        start = 1'b1;
        abort = 1'b1;
        cin_req = 1'b0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_all("start_abort", 3'd1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort_clear", 3'd0, 1'b0);

        // Asynchronous clear in the middle of OP3.
        cin_req = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        chk("clr.in_op3", 32'(step), 32'd5);
        #1 clr = 1'b1;
        #1;
        chk_all("clr.async", 3'd0, 1'b0);
        tick();
        chk_all("clr.held", 3'd0, 1'b0);
        clr = 1'b0;
        tick();
        run_prog("after_clr", 1'b0, 1'b0);

        // HOLD=1 with START held: 7 busy cycles, one IDLE, repeat.
        start2 = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("b2b.busy.c%0d", c), 32'(busy2), 32'(((c - 1) % 8) != 7));
            chk($sformatf("b2b.done.c%0d", c), 32'(done2), 32'(((c - 1) % 8) == 6));
            tick();
        end
        start2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
